mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side end of the LC-3b request/response memory interface: accepts mem_read/mem_write requests from the CPU's arbiter, services them from an on-chip word array after a programmable latency, and returns a single-cycle mem_resp.
- Replaces the testbench memory model so the full pipeline, including arbiter stalls, can be exercised in synthesisable form.
- Sits directly on the CPU's top-level memory ports; no other agents.

Parameters:
- ADDR_BITS, 8, word-address width; array depth 2**ADDR_BITS words of 16 bits
- READ_LATENCY, 3, cycles from request sample to mem_resp for reads; legal 1..15
- WRITE_LATENCY, 2, cycles from request sample to mem_resp for writes; legal 1..15

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_read  in  1  read request, held by initiator until mem_resp
- mem_write  in  1  write request, held by initiator until mem_resp
- mem_address  in  16 (lc3b_word)  byte address; word index = mem_address[ADDR_BITS:1]
- mem_wdata  in  16 (lc3b_word)  write data
- mem_byte_enable  in  2 (lc3b_mem_wmask)  bit0 = low byte, bit1 = high byte
- mem_resp  out  1  one-cycle completion pulse
- mem_rdata  out  16 (lc3b_word)  read data, registered
- busy  out  1  high in BUSY or RESP
- proto_err  out  1  sticky protocol-error flag
- rd_count  out  16  completed reads, wraps 0xFFFF->0x0000
- wr_count  out  16  completed writes, wraps

Behaviour:
- Reset values: state IDLE, mem_resp 0, mem_rdata 0x0000, busy 0, proto_err 0, rd_count 0, wr_count 0. Array contents are not cleared by reset and are undefined at power-up.
- Reset asserted mid-transaction returns to IDLE immediately. No resp is issued. A write not yet committed is dropped.

FSM states: IDLE, BUSY, RESP.

IDLE:
- Samples mem_read|mem_write each edge.
- On a request, latches the address word index, wdata, byte_enable and op (write if mem_write).
- Loads the latency counter with LAT-1, where LAT is the latency for the op.
- Goes to BUSY if LAT>1, else RESP.
- mem_read and mem_write high together: set proto_err (sticky until rst), treat as write.

BUSY:
- Counter decrements each edge.
- When the counter reaches 1, goes to RESP.
- If both mem_read and mem_write drop while BUSY (abort): return to IDLE, no commit, no resp, counters unchanged.

Commit (on the edge entering RESP):
- Read: mem_rdata <= array[idx].
- Write: bytes with enable=1 are updated; byte_enable 2'b00 writes nothing but still completes. mem_rdata is unchanged by a write.

RESP:
- mem_resp=1 for exactly one cycle.
- Increments rd_count or wr_count.
- Unconditionally goes to IDLE.
- A request still held in the following IDLE cycle is treated as a new request, so back-to-back accesses are spaced LAT+1 cycles.

Timing and data rules:
- Timing: request first high in cycle N gives mem_resp high in cycle N+LAT.
- mem_rdata holds its value until the next read commits.
- Address bit 0 is ignored. Address bits above ADDR_BITS alias (wrap) into the array.
- Request inputs are ignored while in BUSY/RESP, except for abort detection. Changes to address/data after sampling have no effect.

Decomposition:
- lc3b_types gains: enum mem_resp_state_t {IDLE, BUSY, RESP}; constant MEM_LAT_W = 4.
- lc3b_word and lc3b_mem_wmask are reused from lc3b_types.
- One sub-module: mem_array, with synchronous read, synchronous byte-masked write, and one port. The FSM and counters stay in mem_responder.

Test Plan:
- Write 0xBEEF to 0x0010 with be=11 (WRITE_LATENCY=2), then read 0x0010 -> write resp 2 cycles after request, read resp 3 cycles after its request, mem_rdata=0xBEEF, wr_count=1, rd_count=1.
- Byte masks: write 0x1234 to 0x0020 with be=11, then 0xAB00 with be=10, then 0x00CD with be=01, then read 0x0020 -> 0xABCD. Also write 0xFFFF with be=00, then read -> 0xABCD unchanged.
- Aliasing: with ADDR_BITS=8, write 0x5555 to 0x0202, then read 0x0002 -> 0x5555. Also read 0x0003 -> 0x5555.
- Abort: assert mem_read for 1 cycle with READ_LATENCY=3, then drop it -> no mem_resp, rd_count=0, busy back to 0 within 1 cycle. Reset asserted in BUSY during a write of 0x1111 over 0x2222 -> readback 0x2222.
- Back-to-back: hold mem_read high for two reads (READ_LATENCY=1) -> resp pulses in cycles N+1 and N+3, never on consecutive cycles.
- Protocol error: assert mem_read and mem_write together with wdata 0x7777 -> proto_err=1 and stays 1. The write commits (readback 0x7777). proto_err clears only on rst.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared LC-3b memory-interface types and the request/response FSM encoding
// used by mem_responder and its word array.
package mem_responder_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    localparam int MEM_LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    // Writes win when both request lines are high, so the latency follows the write.
    function automatic logic [MEM_LAT_W-1:0] op_latency(
        input logic                 is_write,
        input logic [MEM_LAT_W-1:0] rd_lat,
        input logic [MEM_LAT_W-1:0] wr_lat
    );
        if (is_write) begin
            return wr_lat;
        end else begin
            return rd_lat;
        end
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port word array: synchronous byte-masked write, synchronous read into
// a reset-able output register that holds until the next read.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 we,
    input  lc3b_mem_wmask        be,
    input  logic [ADDR_BITS-1:0] addr,
    input  lc3b_word             wdata,
    output lc3b_word             rdata
);

    lc3b_word mem_r [0:(1<<ADDR_BITS)-1];

    // Byte-masked write port; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            if (be[0]) begin
                mem_r[addr][7:0] <= wdata[7:0];
            end
            if (be[1]) begin
                mem_r[addr][15:8] <= wdata[15:8];
            end
        end
    end

    // Read register only loads on a read, so writes never disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 16'h0000;
        end else if (en && !we) begin
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the LC-3b request/response interface: services
// held mem_read/mem_write requests after a fixed latency and pulses mem_resp.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_word      mem_address,
    input  lc3b_word      mem_wdata,
    input  lc3b_mem_wmask mem_byte_enable,
    output logic          mem_resp,
    output lc3b_word      mem_rdata,
    output logic          busy,
    output logic          proto_err,
    output logic [15:0]   rd_count,
    output logic [15:0]   wr_count
);

    localparam logic [MEM_LAT_W-1:0] RD_LAT = MEM_LAT_W'(READ_LATENCY);
    localparam logic [MEM_LAT_W-1:0] WR_LAT = MEM_LAT_W'(WRITE_LATENCY);

    mem_resp_state_t       state_r;
    logic [MEM_LAT_W-1:0]  cnt_r;
    logic [ADDR_BITS-1:0]  idx_r;
    lc3b_word              wdata_r;
    lc3b_mem_wmask         be_r;
    logic                  is_wr_r;
    logic                  mem_resp_r;
    logic                  busy_r;
    logic                  proto_err_r;
    logic [15:0]           rd_count_r;
    logic [15:0]           wr_count_r;

    logic                  req_s;
    logic [MEM_LAT_W-1:0]  req_lat_s;
    logic                  commit_s;
    logic                  arr_wr_s;
    logic [ADDR_BITS-1:0]  arr_idx_s;
    lc3b_word              arr_wdata_s;
    lc3b_mem_wmask         arr_be_s;
    logic                  unused_addr_s;

    assign req_s         = mem_read | mem_write;
    assign req_lat_s     = op_latency(mem_write, RD_LAT, WR_LAT);
    assign unused_addr_s = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

    // Commit strobe for the array; a latency-1 access commits straight from IDLE
    // so it must use the live request fields instead of the latched ones.
    always_comb begin
        commit_s    = 1'b0;
        arr_wr_s    = is_wr_r;
        arr_idx_s   = idx_r;
        arr_wdata_s = wdata_r;
        arr_be_s    = be_r;
        case (state_r)
            IDLE: begin
                arr_wr_s    = mem_write;
                arr_idx_s   = mem_address[ADDR_BITS:1];
                arr_wdata_s = mem_wdata;
                arr_be_s    = mem_byte_enable;
                if (req_s && (req_lat_s == 4'd1)) begin
                    commit_s = 1'b1;
                end else begin
                    commit_s = 1'b0;
                end
            end
            BUSY: begin
                if (req_s && (cnt_r == 4'd1)) begin
                    commit_s = 1'b1;
                end else begin
                    commit_s = 1'b0;
                end
            end
            default: begin
                commit_s = 1'b0;
            end
        endcase
    end

    mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (commit_s),
        .we    (arr_wr_s),
        .be    (arr_be_s),
        .addr  (arr_idx_s),
        .wdata (arr_wdata_s),
        .rdata (mem_rdata)
    );

    // Request FSM, latency counter, status flags and completion counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            idx_r       <= '0;
            wdata_r     <= 16'h0000;
            be_r        <= 2'b00;
            is_wr_r     <= 1'b0;
            mem_resp_r  <= 1'b0;
            busy_r      <= 1'b0;
            proto_err_r <= 1'b0;
            rd_count_r  <= 16'h0000;
            wr_count_r  <= 16'h0000;
        end else begin
            mem_resp_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        idx_r   <= mem_address[ADDR_BITS:1];
                        wdata_r <= mem_wdata;
                        be_r    <= mem_byte_enable;
                        is_wr_r <= mem_write;
                        cnt_r   <= req_lat_s - 4'd1;
                        busy_r  <= 1'b1;
                        if (mem_read && mem_write) begin
                            proto_err_r <= 1'b1;
                        end
                        if (req_lat_s > 4'd1) begin
                            state_r <= BUSY;
                        end else begin
                            state_r    <= RESP;
                            mem_resp_r <= 1'b1;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                BUSY: begin
                    // Dropping both request lines aborts without a response.
                    if (!req_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == 4'd1) begin
                        state_r    <= RESP;
                        mem_resp_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    if (is_wr_r) begin
                        wr_count_r <= wr_count_r + 16'd1;
                    end else begin
                        rd_count_r <= rd_count_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_resp  = mem_resp_r;
    assign busy      = busy_r;
    assign proto_err = proto_err_r;
    assign rd_count  = rd_count_r;
    assign wr_count  = wr_count_r;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a transaction-level model
// (reference word array plus expected response/busy windows per request).
module tb_mem_responder;

    localparam int RD_LAT = 3;
    localparam int WR_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [15:0] mem_address = 16'h0, mem_wdata = 16'h0;
    logic [1:0]  mem_byte_enable = 2'b00;
    logic        mem_resp, busy, proto_err;
    logic [15:0] mem_rdata, rd_count, wr_count;

    logic        f_read = 1'b0;
    logic [15:0] f_addr = 16'h0;
    logic        f_resp, f_busy, f_proto;
    logic [15:0] f_rdata, f_rdc, f_wrc;
    logic [4:0]  f_bits;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Model state
    logic [15:0] ref_mem [256];
    logic [15:0] m_rdata = 16'h0, m_rd = 16'h0, m_wr = 16'h0;
    logic        m_proto = 1'b0;
    int m_busy_from = 0, m_busy_to = -1, m_resp_cyc = -1;
    int issue_cyc = 0, last_resp_cyc = -100;

    mem_responder #(.ADDR_BITS(8), .READ_LATENCY(RD_LAT), .WRITE_LATENCY(WR_LAT)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .busy(busy), .proto_err(proto_err),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    mem_responder #(.ADDR_BITS(8), .READ_LATENCY(1), .WRITE_LATENCY(1)) u_fast (
        .clk(clk), .rst(rst), .mem_read(f_read), .mem_write(1'b0),
        .mem_address(f_addr), .mem_wdata(16'h0000), .mem_byte_enable(2'b00),
        .mem_resp(f_resp), .mem_rdata(f_rdata), .busy(f_busy), .proto_err(f_proto),
        .rd_count(f_rdc), .wr_count(f_wrc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("resp", {15'd0, mem_resp}, {15'd0, cyc == m_resp_cyc});
            chk("busy", {15'd0, busy}, {15'd0, (cyc >= m_busy_from) && (cyc <= m_busy_to)});
            chk("rdata", mem_rdata, m_rdata);
            chk("proto_err", {15'd0, proto_err}, {15'd0, m_proto});
            chk("rd_count", rd_count, m_rd);
            chk("wr_count", wr_count, m_wr);
            if (mem_resp === 1'b1) last_resp_cyc = cyc;
        end
    end

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; f_read = 1'b0;
        m_rdata = 16'h0; m_rd = 16'h0; m_wr = 16'h0; m_proto = 1'b0;
        m_busy_to = -1; m_resp_cyc = -1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 chk_en = 1'b1;
    endtask

    // One request held until response (abort_k==0) or dropped after abort_k cycles
    task automatic txn(input bit wr, input bit both, input logic [15:0] addr,
                       input logic [15:0] data, input logic [1:0] be, input int abort_k);
        int lat, n, steps, idx;
        bit is_w;
        is_w = wr || both;
        lat = is_w ? WR_LAT : RD_LAT;
        idx = int'(addr[8:1]);
        @(posedge clk);
        #1;
        mem_read = !wr || both;
        mem_write = is_w;
        mem_address = addr; mem_wdata = data; mem_byte_enable = be;
        n = cyc;
        issue_cyc = n;
        m_busy_from = n + 1;
        m_busy_to = (abort_k > 0) ? n + abort_k : n + lat;
        m_resp_cyc = (abort_k > 0) ? -1 : n + lat;
        steps = (abort_k > 0) ? abort_k : lat;
        for (int j = 1; j <= steps; j++) begin
            @(posedge clk);
            #1;
            if (j == 1 && both) m_proto = 1'b1;
            mem_address = 16'($urandom); mem_wdata = 16'($urandom);
            mem_byte_enable = 2'($urandom);
        end
        if (abort_k == 0) begin
            if (is_w) begin
                if (be[0]) ref_mem[idx][7:0] = data[7:0];
                if (be[1]) ref_mem[idx][15:8] = data[15:8];
            end else begin
                m_rdata = ref_mem[idx];
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        if (abort_k == 0) begin
            @(posedge clk);
            #1;
            if (is_w) m_wr = m_wr + 16'd1;
            else m_rd = m_rd + 16'd1;
        end
    endtask

    initial begin
        int n;
        bit w, b;
        do_reset();
        chk("rst_resp", {15'd0, mem_resp}, 16'h0000);
        chk("rst_rdata", mem_rdata, 16'h0000);
        chk("rst_busy", {15'd0, busy}, 16'h0000);
        chk("rst_proto", {15'd0, proto_err}, 16'h0000);
        chk("rst_counts", rd_count | wr_count, 16'h0000);

        // Back-to-back reads on the latency-1 instance: pulses at N+1 and N+3
        @(posedge clk);
        #1 f_read = 1'b1; f_addr = 16'h0004;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            f_bits[j] = f_resp;
        end
        f_read = 1'b0;
        chk("b2b_pulses", {11'd0, f_bits}, 16'h000A);

        txn(1'b1, 1'b0, 16'h0010, 16'hBEEF, 2'b11, 0);
        chk("wr_latency", 16'(last_resp_cyc - issue_cyc), 16'd2);
        txn(1'b0, 1'b0, 16'h0010, 16'h0000, 2'b00, 0);
        chk("rd_latency", 16'(last_resp_cyc - issue_cyc), 16'd3);
        chk("beef", mem_rdata, 16'hBEEF);
        chk("wr_count_1", wr_count, 16'd1);
        chk("rd_count_1", rd_count, 16'd1);

        txn(1'b1, 1'b0, 16'h0020, 16'h1234, 2'b11, 0);
        txn(1'b1, 1'b0, 16'h0020, 16'hAB00, 2'b10, 0);
        txn(1'b1, 1'b0, 16'h0020, 16'h00CD, 2'b01, 0);
        txn(1'b0, 1'b0, 16'h0020, 16'h0000, 2'b00, 0);
        chk("bytemask", mem_rdata, 16'hABCD);
        txn(1'b1, 1'b0, 16'h0020, 16'hFFFF, 2'b00, 0);
        txn(1'b0, 1'b0, 16'h0020, 16'h0000, 2'b00, 0);
        chk("be00", mem_rdata, 16'hABCD);

        txn(1'b1, 1'b0, 16'h0202, 16'h5555, 2'b11, 0);
        txn(1'b0, 1'b0, 16'h0002, 16'h0000, 2'b00, 0);
        chk("alias_hi", mem_rdata, 16'h5555);
        txn(1'b0, 1'b0, 16'h0003, 16'h0000, 2'b00, 0);
        chk("alias_b0", mem_rdata, 16'h5555);

        for (int i = 0; i < 256; i++)
            txn(1'b1, 1'b0, 16'(i * 2), 16'($urandom), 2'b11, 0);

        for (int i = 0; i < 300; i++) begin
            w = 1'($urandom);
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(1, (w ? WR_LAT : RD_LAT) - 1) : 0;
            txn(w, 1'b0, 16'($urandom), 16'($urandom), 2'($urandom), n);
        end

        // Reset while a write sits in BUSY: the write must be dropped
        txn(1'b1, 1'b0, 16'h0040, 16'h2222, 2'b11, 0);
        @(posedge clk);
        #1 mem_write = 1'b1; mem_address = 16'h0040; mem_wdata = 16'h1111;
        mem_byte_enable = 2'b11;
        @(posedge clk);
        #1 do_reset();

        txn(1'b0, 1'b0, 16'h0040, 16'h0000, 2'b00, 1);
        @(posedge clk);
        #1;
        chk("abort_busy", {15'd0, busy}, 16'h0000);
        chk("abort_rd_count", rd_count, 16'h0000);
        txn(1'b0, 1'b0, 16'h0040, 16'h0000, 2'b00, 0);
        chk("rst_drop_wr", mem_rdata, 16'h2222);

        txn(1'b1, 1'b1, 16'h0050, 16'h7777, 2'b11, 0);
        chk("proto_set", {15'd0, proto_err}, 16'h0001);
        txn(1'b0, 1'b0, 16'h0050, 16'h0000, 2'b00, 0);
        chk("proto_commit", mem_rdata, 16'h7777);
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom);
            b = ($urandom_range(0, 3) == 0);
            txn(w, b, 16'($urandom), 16'($urandom), 2'($urandom), 0);
        end
        chk("proto_sticky", {15'd0, proto_err}, 16'h0001);
        do_reset();
        chk("proto_clear", {15'd0, proto_err}, 16'h0000);

        @(posedge clk);
        #1 chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
